// File: rtl/cast_stage_pkg.sv
// -----------------------------------------------------------------------------
// cast_stage_pkg
//   Shared types for the 24-bit width-cast stage and its downstream consumers.
//   - CAST_DATA_W : width of a cast result word
//   - CAST_ACC_W  : widest supported block-sum width
//   - acc_state_t : block accumulator FSM states
//   - acc_rec_t   : one per-block summary record (sum, OR, word count, overflow)
// -----------------------------------------------------------------------------
package cast_stage_pkg;

  localparam int CAST_DATA_W = 24;
  localparam int CAST_ACC_W  = 32;
  localparam int CAST_CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } acc_state_t;

  // The OR field cannot be called "or" (reserved word), hence "bor".
  typedef struct packed {
    logic [CAST_ACC_W-1:0]  sum;
    logic [CAST_DATA_W-1:0] bor;
    logic [CAST_CNT_W-1:0]  count;
    logic                   ovf;
  } acc_rec_t;

endpackage : cast_stage_pkg

// File: rtl/cast_result_accumulator.sv
// -----------------------------------------------------------------------------
// cast_result_accumulator
//   Consumes unsigned cast results over a valid/ready stream, sums and ORs them
//   in blocks of BLOCK_LEN words (or shorter blocks closed by flush), and
//   presents one summary record per block to a sink that may stall.
//
// Parameters
//   DATA_W    : input word width (<= CAST_DATA_W), zero-extended into the sum
//   BLOCK_LEN : words per full block, 1..255
//   ACC_W     : sum width, DATA_W <= ACC_W <= CAST_ACC_W; sum wraps mod 2^ACC_W
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset, drops any partial block/record
//   in_valid   : in_data valid
//   in_ready   : word accepted this cycle when in_valid is also high
//   in_data    : cast result word
//   flush      : close the current partial block (level, sampled every cycle)
//   out_valid  : summary record valid
//   out_ready  : sink accepts the record
//   out_sum    : modulo-2^ACC_W sum of the block words
//   out_or     : bitwise OR of the block words
//   out_count  : number of words in the block (1..BLOCK_LEN)
//   out_ovf    : some add in the block carried out of ACC_W
// -----------------------------------------------------------------------------
module cast_result_accumulator
  import cast_stage_pkg::*;
#(
  parameter int DATA_W    = CAST_DATA_W,
  parameter int BLOCK_LEN = 8,
  parameter int ACC_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_or,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  // Zero-extending add that also returns the carry out of ACC_W in the MSB.
  function automatic logic [ACC_W:0] add_carry(
    input logic [ACC_W-1:0]  a,
    input logic [DATA_W-1:0] b
  );
    return {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, b};
  endfunction

  acc_state_t r_state;
  acc_state_t w_state_next;

  logic [ACC_W-1:0]  r_acc_p0;
  logic [DATA_W-1:0] r_or_p0;
  logic [CNT_W-1:0]  r_cnt_p0;
  logic              r_ovf_p0;
  acc_rec_t          r_rec_p1;

  logic              w_hs_in;
  logic              w_hs_out;
  logic              w_close;
  logic [ACC_W:0]    w_add;
  logic [ACC_W-1:0]  w_acc_next;
  logic [DATA_W-1:0] w_or_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_ovf_next;

  // The record is held in the package-wide record type, which may be wider
  // than this instance's ACC_W/DATA_W; the spare upper bits are always zero.
  logic              w_unused_rec;

  // A pending record blocks input unless the sink takes it this same cycle;
  // this is the only combinational path through the block.
  assign in_ready = (r_state == ACCUM) | out_ready;
  assign w_hs_in  = in_valid & in_ready;
  assign w_hs_out = (r_state == EMIT) & out_ready;

  // ---------------------------------------------------------------- stage p0
  // Block running values including the word handshaked this cycle. While a
  // record is pending the accumulators are already clear, so a word accepted
  // alongside the retiring record naturally becomes word 1 of the next block.
  assign w_add      = add_carry(r_acc_p0, in_data);
  assign w_acc_next = w_hs_in ? w_add[ACC_W-1:0] : r_acc_p0;
  assign w_or_next  = w_hs_in ? (r_or_p0 | in_data) : r_or_p0;
  assign w_cnt_next = r_cnt_p0 + CNT_W'(w_hs_in);
  assign w_ovf_next = r_ovf_p0 | (w_hs_in & w_add[ACC_W]);

  // A flush with nothing accumulated and no word arriving closes nothing, so
  // an empty record is never produced.
  assign w_close = (w_hs_in & (r_cnt_p0 == LAST_IDX))
                 | (flush & ((r_cnt_p0 != '0) | w_hs_in));

  // ---------------------------------------------------------------- stage p1
  // Accumulators and the output record. The record only changes on a close,
  // and a close can only happen while no record is pending or while the
  // pending one retires, so a stalled record stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_p0 <= '0;
      r_or_p0  <= '0;
      r_cnt_p0 <= '0;
      r_ovf_p0 <= 1'b0;
      r_rec_p1 <= '0;
    end else if (w_close) begin
      r_acc_p0       <= '0;
      r_or_p0        <= '0;
      r_cnt_p0       <= '0;
      r_ovf_p0       <= 1'b0;
      r_rec_p1.sum   <= CAST_ACC_W'(w_acc_next);
      r_rec_p1.bor   <= CAST_DATA_W'(w_or_next);
      r_rec_p1.count <= w_cnt_next;
      r_rec_p1.ovf   <= w_ovf_next;
    end else begin
      r_acc_p0 <= w_acc_next;
      r_or_p0  <= w_or_next;
      r_cnt_p0 <= w_cnt_next;
      r_ovf_p0 <= w_ovf_next;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. A close always (re)enters EMIT, which gives
  // back-to-back records when a retiring record coincides with a new close.
  always_comb begin
    w_state_next = r_state;
    if (w_close) begin
      w_state_next = EMIT;
    end else if (w_hs_out) begin
      w_state_next = ACCUM;
    end
  end

  // FSM: outputs.
  always_comb begin
    out_valid = (r_state == EMIT);
  end

  assign out_sum   = r_rec_p1.sum[ACC_W-1:0];
  assign out_or    = r_rec_p1.bor[DATA_W-1:0];
  assign out_count = r_rec_p1.count;
  assign out_ovf   = r_rec_p1.ovf;

  assign w_unused_rec = ^{r_rec_p1.sum, r_rec_p1.bor};

endmodule : cast_result_accumulator

// File: tb/tb_cast_result_accumulator.sv
// -----------------------------------------------------------------------------
// tb_cast_result_accumulator
//   Three instances: A (BLOCK_LEN=8, ACC_W=32), B (BLOCK_LEN=8, ACC_W=24) and
//   C (BLOCK_LEN=1, ACC_W=32). A runs a table of per-cycle vectors followed by
//   a backpressure sequence; B covers sum wrap and sticky overflow; C covers
//   single-word blocks and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_cast_result_accumulator;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic        rst_a, iv_a, ir_a, fl_a, ov_a, ordy_a, ovf_a;
  logic [23:0] id_a, or_a;
  logic [31:0] sum_a;
  logic [7:0]  cnt_a;
  // Instance B
  logic        rst_b, iv_b, ir_b, fl_b, ov_b, ordy_b, ovf_b;
  logic [23:0] id_b, or_b;
  logic [23:0] sum_b;
  logic [7:0]  cnt_b;
  // Instance C
  logic        rst_c, iv_c, ir_c, fl_c, ov_c, ordy_c, ovf_c;
  logic [23:0] id_c, or_c;
  logic [31:0] sum_c;
  logic [7:0]  cnt_c;

  cast_result_accumulator #(.DATA_W(24), .BLOCK_LEN(8), .ACC_W(32)) u_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .flush(fl_a), .out_valid(ov_a), .out_ready(ordy_a), .out_sum(sum_a),
    .out_or(or_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  cast_result_accumulator #(.DATA_W(24), .BLOCK_LEN(8), .ACC_W(24)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .flush(fl_b), .out_valid(ov_b), .out_ready(ordy_b), .out_sum(sum_b),
    .out_or(or_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  cast_result_accumulator #(.DATA_W(24), .BLOCK_LEN(1), .ACC_W(32)) u_c (
    .clk(clk), .rst(rst_c), .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
    .flush(fl_c), .out_valid(ov_c), .out_ready(ordy_c), .out_sum(sum_c),
    .out_or(or_c), .out_count(cnt_c), .out_ovf(ovf_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [23:0] d;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_sum;
    logic [23:0] e_or;
    logic [7:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Vectors for instance A: inputs held for one cycle; e_ir checked before
    // the edge, the record fields after it.
    for (int k = 0; k < 7; k++)
      tbl[k] = '{1'b1, 24'(k + 1), 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 24'h0, 8'd0, 1'b0};
    tbl[7]  = '{1'b1, 24'd8,    1'b0, 1'b1, 1'b1, 1'b1, 32'd36,   24'h00000F, 8'd8, 1'b0};
    tbl[8]  = '{1'b0, 24'd0,    1'b0, 1'b1, 1'b1, 1'b0, 32'd36,   24'h00000F, 8'd8, 1'b0};
    tbl[9]  = '{1'b1, 24'h10,   1'b0, 1'b1, 1'b1, 1'b0, 32'd36,   24'h00000F, 8'd8, 1'b0};
    tbl[10] = '{1'b1, 24'h20,   1'b0, 1'b1, 1'b1, 1'b0, 32'd36,   24'h00000F, 8'd8, 1'b0};
    tbl[11] = '{1'b1, 24'h40,   1'b0, 1'b1, 1'b1, 1'b0, 32'd36,   24'h00000F, 8'd8, 1'b0};
    tbl[12] = '{1'b0, 24'd0,    1'b1, 1'b1, 1'b1, 1'b1, 32'h70,   24'h000070, 8'd3, 1'b0};
    tbl[13] = '{1'b0, 24'd0,    1'b1, 1'b1, 1'b1, 1'b0, 32'h70,   24'h000070, 8'd3, 1'b0};
    tbl[14] = '{1'b0, 24'd0,    1'b1, 1'b1, 1'b1, 1'b0, 32'h70,   24'h000070, 8'd3, 1'b0};
    tbl[15] = '{1'b1, 24'd5,    1'b1, 1'b1, 1'b1, 1'b1, 32'd5,    24'h000005, 8'd1, 1'b0};
    tbl[16] = '{1'b0, 24'd0,    1'b0, 1'b1, 1'b1, 1'b0, 32'd5,    24'h000005, 8'd1, 1'b0};

    // Reset with input and flush active on every instance.
    rst_a = 1; iv_a = 1; id_a = 24'h123; fl_a = 1; ordy_a = 0;
    rst_b = 1; iv_b = 1; id_b = 24'h456; fl_b = 1; ordy_b = 0;
    rst_c = 1; iv_c = 1; id_c = 24'h789; fl_c = 1; ordy_c = 0;
    tick();
    tick();
    rst_a = 0; iv_a = 0; fl_a = 0;
    rst_b = 0; iv_b = 0; fl_b = 0;
    rst_c = 0; iv_c = 0; fl_c = 0;
    #1;
    chk("rst_a_valid", ov_a, 0);
    chk("rst_a_sum", sum_a, 0);
    chk("rst_a_or", or_a, 0);
    chk("rst_a_cnt", cnt_a, 0);
    chk("rst_a_ovf", ovf_a, 0);
    chk("rst_a_ready", ir_a, 1);
    chk("rst_b_valid", ov_b, 0);
    chk("rst_b_ready", ir_b, 1);
    chk("rst_c_valid", ov_c, 0);
    chk("rst_c_sum", sum_c, 0);
    tick();
    chk("rst_a_idle_valid", ov_a, 0);

    // Table-driven: full block 1..8, partial block + flush, empty flushes,
    // flush together with the closing word.
    for (int i = 0; i < 17; i++) begin
      iv_a = tbl[i].iv; id_a = tbl[i].d; fl_a = tbl[i].fl; ordy_a = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), ir_a, tbl[i].e_ir);
      tick();
      chk($sformatf("v%0d_valid", i), ov_a, tbl[i].e_ov);
      chk($sformatf("v%0d_sum", i), sum_a, tbl[i].e_sum);
      chk($sformatf("v%0d_or", i), or_a, tbl[i].e_or);
      chk($sformatf("v%0d_count", i), cnt_a, tbl[i].e_cnt);
      chk($sformatf("v%0d_ovf", i), ovf_a, tbl[i].e_ovf);
    end

    // Backpressure: record 3+4 held for 5 stalled cycles.
    iv_a = 1; id_a = 24'h3; fl_a = 0; ordy_a = 0;
    tick();
    chk("bp_first_valid", ov_a, 0);
    iv_a = 1; id_a = 24'h4; fl_a = 1; ordy_a = 0;
    #1;
    chk("bp_close_ready", ir_a, 1);
    tick();
    chk("bp_rec_valid", ov_a, 1);
    chk("bp_rec_sum", sum_a, 32'd7);
    chk("bp_rec_cnt", cnt_a, 8'd2);
    for (int i = 0; i < 5; i++) begin
      iv_a = 1; id_a = 24'h99; fl_a = 0; ordy_a = 0;
      #1;
      chk($sformatf("bp_stall%0d_ready", i), ir_a, 0);
      tick();
      chk($sformatf("bp_stall%0d_valid", i), ov_a, 1);
      chk($sformatf("bp_stall%0d_sum", i), sum_a, 32'd7);
      chk($sformatf("bp_stall%0d_or", i), or_a, 24'h7);
      chk($sformatf("bp_stall%0d_cnt", i), cnt_a, 8'd2);
    end
    // Retire with a word accepted in the same cycle: it becomes word 1.
    iv_a = 1; id_a = 24'h9; fl_a = 0; ordy_a = 1;
    #1;
    chk("bp_retire_ready", ir_a, 1);
    tick();
    chk("bp_retire_valid", ov_a, 0);
    iv_a = 1; id_a = 24'h1; fl_a = 1; ordy_a = 1;
    tick();
    chk("bp_next_valid", ov_a, 1);
    chk("bp_next_sum", sum_a, 32'hA);
    chk("bp_next_or", or_a, 24'h9);
    chk("bp_next_cnt", cnt_a, 8'd2);
    iv_a = 0; fl_a = 0;
    tick();
    chk("bp_next_retired", ov_a, 0);

    // Instance B: wrap at 24 bits with sticky overflow, then a clean block.
    ordy_b = 1;
    iv_b = 1; id_b = 24'hFFFFFF; fl_b = 0;
    tick();
    tick();
    iv_b = 0; fl_b = 1;
    tick();
    chk("ovf_valid", ov_b, 1);
    chk("ovf_sum", sum_b, 24'hFFFFFE);
    chk("ovf_or", or_b, 24'hFFFFFF);
    chk("ovf_cnt", cnt_b, 8'd2);
    chk("ovf_flag", ovf_b, 1);
    fl_b = 0;
    tick();
    chk("ovf_retired", ov_b, 0);
    iv_b = 1; id_b = 24'h1; fl_b = 1;
    tick();
    chk("ovf_next_valid", ov_b, 1);
    chk("ovf_next_sum", sum_b, 24'h1);
    chk("ovf_next_flag", ovf_b, 0);
    iv_b = 0; fl_b = 0;
    tick();

    // Instance C: one record per cycle with no bubble, then reset mid-stream.
    ordy_c = 1;
    for (int k = 1; k <= 6; k++) begin
      iv_c = 1; id_c = 24'(k * 3);
      #1;
      chk($sformatf("b2b%0d_ready", k), ir_c, 1);
      tick();
      chk($sformatf("b2b%0d_valid", k), ov_c, 1);
      chk($sformatf("b2b%0d_sum", k), sum_c, 32'(k * 3));
      chk($sformatf("b2b%0d_or", k), or_c, 24'(k * 3));
      chk($sformatf("b2b%0d_cnt", k), cnt_c, 8'd1);
    end
    rst_c = 1; iv_c = 1; id_c = 24'h77;
    tick();
    chk("midrst_valid", ov_c, 0);
    chk("midrst_sum", sum_c, 0);
    chk("midrst_or", or_c, 0);
    chk("midrst_cnt", cnt_c, 0);
    chk("midrst_ovf", ovf_c, 0);
    rst_c = 0; iv_c = 0;
    tick();
    chk("midrst_idle_valid", ov_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cast_result_accumulator
